memory_arbiter: RTL and testbench

//  Shares the single memory_controller bus between the CPU instruction-fetch port and the data port.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/memory_arbiter.sv | 170 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory_controller bus arbiter.
// FSM states and round-robin grant encodings.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

endpackage

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing the memory_controller bus between fetch and data.
// Drives the enable / busy-rise / busy-fall handshake and returns a one-cycle ack.
module memory_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE    = 64,
    parameter int DATA_SIZE    = 64,
    parameter int BYTE_NUM     = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 inst_req,
    input  logic [ADDR_SIZE-1:0] inst_addr,
    output logic [DATA_SIZE-1:0] inst_rd_data,
    output logic                 inst_ack,
    input  logic                 data_rd_req,
    input  logic                 data_wr_req,
    input  logic [ADDR_SIZE-1:0] data_addr,
    input  logic [BYTE_NUM-1:0]  data_byte_en,
    input  logic [DATA_SIZE-1:0] data_wr_data,
    output logic [DATA_SIZE-1:0] data_rd_data,
    output logic                 data_ack,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [BYTE_NUM-1:0]  mem_byte_en,
    output logic [DATA_SIZE-1:0] mem_wr_data,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic [DATA_SIZE-1:0] mem_rd_data,
    input  logic                 mem_busy
);

    localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    state_t state_q, state_d;
    logic grant_q, grant_d;
    logic last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                 rd_en_d, wr_en_d;
    logic [BYTE_NUM-1:0]  byte_en_d;
    logic [DATA_SIZE-1:0] wr_data_d;
    logic [ADDR_SIZE-1:0] addr_d;
    logic [DATA_SIZE-1:0] inst_data_d, data_data_d;
    logic                 inst_ack_d, data_ack_d;
    logic                 finish;

    logic data_any;
    logic pick_data;

    assign data_any  = data_rd_req | data_wr_req;
    // On a tie the port that did not win last time goes next.
    assign pick_data = data_any & (~inst_req | (last_q == GRANT_INST));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        rd_en_d     = mem_rd_en;
        wr_en_d     = mem_wr_en;
        byte_en_d   = mem_byte_en;
        wr_data_d   = mem_wr_data;
        addr_d      = mem_addr;
        inst_data_d = inst_rd_data;
        data_data_d = data_rd_data;
        inst_ack_d  = 1'b0;
        data_ack_d  = 1'b0;
        finish      = 1'b0;

        unique case (state_q)
            IDLE: begin
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                if (!mem_busy && (inst_req || data_any)) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                    if (pick_data) begin
                        grant_d   = GRANT_DATA;
                        addr_d    = data_addr;
                        byte_en_d = data_byte_en;
                        wr_data_d = data_wr_data;
                        wr_en_d   = data_wr_req;
                        rd_en_d   = ~data_wr_req;
                    end else begin
                        grant_d   = GRANT_INST;
                        addr_d    = inst_addr;
                        byte_en_d = '1;
                        wr_data_d = '0;
                        rd_en_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_busy) begin
                    state_d = WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    finish = 1'b1;
                end
            end
            WAIT: begin
                if (!mem_busy) begin
                    finish = 1'b1;
                end
            end
            DONE: begin
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                last_d  = grant_q;
                state_d = IDLE;
            end
        endcase

        if (finish) begin
            state_d = DONE;
            rd_en_d = 1'b0;
            wr_en_d = 1'b0;
            if (grant_q == GRANT_DATA) begin
                data_ack_d = 1'b1;
                if (mem_rd_en) begin
                    data_data_d = mem_rd_data;
                end
            end else begin
                inst_ack_d  = 1'b1;
                inst_data_d = mem_rd_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_q      <= GRANT_INST;
            last_q       <= GRANT_INST;
            cnt_q        <= '0;
            mem_rd_en    <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_byte_en  <= '0;
            mem_wr_data  <= '0;
            mem_addr     <= '0;
            inst_rd_data <= '0;
            data_rd_data <= '0;
            inst_ack     <= 1'b0;
            data_ack     <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            mem_rd_en    <= rd_en_d;
            mem_wr_en    <= wr_en_d;
            mem_byte_en  <= byte_en_d;
            mem_wr_data  <= wr_data_d;
            mem_addr     <= addr_d;
            inst_rd_data <= inst_data_d;
            data_rd_data <= data_data_d;
            inst_ack     <= inst_ack_d;
            data_ack     <= data_ack_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter with a behavioural busy-handshake memory.
// Stimulus pushes expected acks; a monitor pops and compares on every ack.
module tb_memory_arbiter;

    localparam int BT = 4;

    localparam logic [63:0] M0  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] M8  = 64'hCAFE_F00D_0123_4567;
    localparam logic [63:0] M10 = 64'h0BAD_C0DE_7777_8888;
    localparam logic [63:0] D0  = 64'hA5A5_0000_5A5A_FFFF;
    localparam logic [63:0] STUB = 64'hFEED_FACE_0000_0042;

    logic        clock, reset;
    logic        inst_req;
    logic [63:0] inst_addr, inst_rd_data;
    logic        inst_ack;
    logic        data_rd_req, data_wr_req;
    logic [63:0] data_addr, data_wr_data, data_rd_data;
    logic [7:0]  data_byte_en;
    logic        data_ack;
    logic        mem_rd_en, mem_wr_en;
    logic [7:0]  mem_byte_en;
    logic [63:0] mem_wr_data, mem_addr, mem_rd_data;
    logic        mem_busy;

    memory_arbiter #(
        .ADDR_SIZE(64), .DATA_SIZE(64), .BYTE_NUM(8), .BUSY_TIMEOUT(BT)
    ) dut (
        .clock(clock), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_rd_data(inst_rd_data), .inst_ack(inst_ack),
        .data_rd_req(data_rd_req), .data_wr_req(data_wr_req),
        .data_addr(data_addr), .data_byte_en(data_byte_en),
        .data_wr_data(data_wr_data), .data_rd_data(data_rd_data),
        .data_ack(data_ack),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_byte_en(mem_byte_en), .mem_wr_data(mem_wr_data),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_busy(mem_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- memory model ----------------
    logic [63:0] mem [0:255];
    bit          loaded = 1'b0;
    bit          stub_mode = 1'b0;
    int          busy_len = 3;
    int          phase = 0;
    int          bcnt = 0;
    logic [7:0]  m_idx;
    logic        m_rd;

    function automatic logic [7:0] idx(input logic [63:0] a);
        return {a[24], a[9:3]};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [63:0] wd,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++)
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    initial begin
        mem_busy    = 1'b0;
        mem_rd_data = '0;
        m_idx       = '0;
        m_rd        = 1'b0;
    end

    always @(posedge clock) begin
        if (!loaded) begin
            for (int k = 0; k < 256; k++) mem[k] <= '0;
            mem[idx(64'h0)]       <= M0;
            mem[idx(64'h8)]       <= M8;
            mem[idx(64'h10)]      <= M10;
            mem[idx(64'h1000000)] <= D0;
            loaded <= 1'b1;
        end else if (stub_mode) begin
            mem_busy    <= 1'b0;
            mem_rd_data <= STUB;
            phase       <= 0;
        end else begin
            case (phase)
                0: if (mem_rd_en || mem_wr_en) begin
                    m_idx    <= idx(mem_addr);
                    m_rd     <= mem_rd_en;
                    if (mem_wr_en)
                        mem[idx(mem_addr)] <= merge(mem[idx(mem_addr)],
                                                    mem_wr_data, mem_byte_en);
                    mem_busy <= 1'b1;
                    bcnt     <= busy_len - 1;
                    phase    <= 1;
                end
                1: if (bcnt == 0) begin
                    mem_busy <= 1'b0;
                    if (m_rd) mem_rd_data <= mem[m_idx];
                    phase    <= 2;
                end else begin
                    bcnt <= bcnt - 1;
                end
                default: if (!mem_rd_en && !mem_wr_en) phase <= 0;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        port;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          inst_acks = 0;
    int          data_acks = 0;
    int          rd_en_cycles = 0;
    logic [63:0] exp_drd = '0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic p, input logic [63:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (mem_rd_en) rd_en_cycles++;
                check("en_exclusive", {63'd0, mem_rd_en & mem_wr_en}, 64'd0);
                if (inst_ack) inst_acks++;
                if (data_ack) data_acks++;
                if (inst_ack || data_ack) begin
                    check("ack_exclusive", {63'd0, inst_ack & data_ack}, 64'd0);
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL ack_unexpected: got inst=%0b data=%0b, expected none",
                                 inst_ack, data_ack);
                    end else begin
                        mon_e = sb.pop_front();
                        check("ack_port", {63'd0, data_ack}, {63'd0, mon_e.port});
                        if (mon_e.port)
                            check("data_rd_data", data_rd_data, mon_e.data);
                        else
                            check("inst_rd_data", inst_rd_data, mon_e.data);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_xact(input logic port, input logic rd, input logic wr,
                           input logic [63:0] a, input logic [7:0] be,
                           input logic [63:0] wd, output int lat);
        int n0;
        bit seen;
        n0   = -1;
        seen = 1'b0;
        lat  = -1;
        @(negedge clock);
        if (!port) begin
            inst_addr = a;
            inst_req  = 1'b1;
        end else begin
            data_addr    = a;
            data_byte_en = be;
            data_wr_data = wd;
            data_rd_req  = rd;
            data_wr_req  = wr;
        end
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clock);
            if (n0 < 0 && (mem_rd_en || mem_wr_en)) n0 = i;
            seen = port ? data_ack : inst_ack;
            if (seen) lat = i - n0 + 1;
        end
        inst_req    = 1'b0;
        data_rd_req = 1'b0;
        data_wr_req = 1'b0;
        check("ack_arrived", {63'd0, seen}, 64'd1);
    endtask

    task automatic run_both(input int n, input logic [63:0] ib,
                            input logic [63:0] db);
        int ni, nd;
        ni = 0;
        nd = 0;
        @(negedge clock);
        inst_addr    = ib;
        data_addr    = db;
        data_byte_en = 8'hFF;
        inst_req     = 1'b1;
        data_rd_req  = 1'b1;
        for (int i = 0; i < 600 && (ni < n || nd < n); i++) begin
            @(negedge clock);
            if (inst_ack) begin
                ni++;
                if (ni < n) inst_addr = ib + 64'(8 * ni);
                else inst_req = 1'b0;
            end
            if (data_ack) begin
                nd++;
                if (nd < n) data_addr = db + 64'(8 * nd);
                else data_rd_req = 1'b0;
            end
        end
        inst_req    = 1'b0;
        data_rd_req = 1'b0;
        check("both_inst_count", 64'(ni), 64'(n));
        check("both_data_count", 64'(nd), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int  lat;
        int  rd0;
        int  held;
        bit  got;

        reset        = 1'b1;
        inst_req     = 1'b0;
        inst_addr    = '0;
        data_rd_req  = 1'b0;
        data_wr_req  = 1'b0;
        data_addr    = '0;
        data_byte_en = '0;
        data_wr_data = '0;

        repeat (3) @(negedge clock);
        check("rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
        check("rst_wr_en", {63'd0, mem_wr_en}, 64'd0);
        check("rst_acks", {62'd0, inst_ack, data_ack}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_rd_data", inst_rd_data | data_rd_data, 64'd0);
        reset = 1'b0;

        // single fetch
        push(1'b0, M8);
        do_xact(1'b0, 1'b0, 1'b0, 64'h8, 8'h00, 64'h0, lat);
        repeat (3) @(negedge clock);
        check("t1_inst_acks", 64'(inst_acks), 64'd1);
        check("t1_data_acks", 64'(data_acks), 64'd0);
        check("t1_low_word", {32'd0, inst_rd_data[31:0]}, 64'h0123_4567);

        // write then read back, then partial write
        push(1'b1, exp_drd);
        do_xact(1'b1, 1'b0, 1'b1, 64'h1000008, 8'hFF, 64'hDEAD_BEEF, lat);
        exp_drd = 64'h0000_0000_DEAD_BEEF;
        push(1'b1, exp_drd);
        do_xact(1'b1, 1'b1, 1'b0, 64'h1000008, 8'hFF, 64'h0, lat);
        push(1'b1, exp_drd);
        do_xact(1'b1, 1'b0, 1'b1, 64'h1000008, 8'hF0,
                64'h1234_5678_9ABC_DEF0, lat);
        exp_drd = 64'h1234_5678_DEAD_BEEF;
        push(1'b1, exp_drd);
        do_xact(1'b1, 1'b1, 1'b0, 64'h1000008, 8'hFF, 64'h0, lat);

        // read and write both high behaves as a write
        rd0 = rd_en_cycles;
        push(1'b1, exp_drd);
        do_xact(1'b1, 1'b1, 1'b1, 64'h1000010, 8'hFF, 64'h55, lat);
        check("rdwr_no_rd_en", 64'(rd_en_cycles - rd0), 64'd0);

        // minimum latency: busy high for one cycle
        busy_len = 1;
        push(1'b1, exp_drd);
        do_xact(1'b1, 1'b1, 1'b0, 64'h1000008, 8'hFF, 64'h0, lat);
        check("min_latency", 64'(lat), 64'd4);
        busy_len = 3;

        // simultaneous requests right after reset: data first
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset   = 1'b0;
        exp_drd = '0;
        push(1'b1, D0);
        push(1'b0, M0);
        run_both(1, 64'h0, 64'h1000000);

        // continuous contention alternates D,I,D,I,D,I
        push(1'b1, D0);
        push(1'b0, M0);
        push(1'b1, 64'h1234_5678_DEAD_BEEF);
        push(1'b0, M8);
        push(1'b1, 64'h55);
        push(1'b0, M10);
        run_both(3, 64'h0, 64'h1000000);

        // memory stub never raises busy: timeout path
        stub_mode = 1'b1;
        repeat (2) @(negedge clock);
        push(1'b1, STUB);
        do_xact(1'b1, 1'b1, 1'b0, 64'h1000000, 8'hFF, 64'h0, lat);
        check("timeout_latency", 64'(lat), 64'(BT + 1));
        stub_mode = 1'b0;
        repeat (2) @(negedge clock);

        // reset in WAIT while memory stays busy
        busy_len = 8;
        @(negedge clock);
        data_addr    = 64'h1000000;
        data_byte_en = 8'hFF;
        data_rd_req  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            got = mem_busy;
        end
        check("t6_busy_rose", {63'd0, got}, 64'd1);
        @(negedge clock);
        check("t6_enable_in_wait", {63'd0, mem_rd_en}, 64'd1);
        #2;
        reset       = 1'b1;
        data_rd_req = 1'b0;
        inst_addr   = 64'h8;
        inst_req    = 1'b1;
        #1;
        check("t6_async_rd_en", {63'd0, mem_rd_en}, 64'd0);
        check("t6_async_data_ack", {63'd0, data_ack}, 64'd0);
        check("t6_async_rd_data", data_rd_data, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        push(1'b0, M8);
        held = 0;
        for (int i = 0; i < 50 && mem_busy; i++) begin
            check("t6_no_issue_busy", {62'd0, mem_rd_en, mem_wr_en}, 64'd0);
            held++;
            @(negedge clock);
        end
        check("t6_busy_held", {63'd0, held > 0}, 64'd1);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            got = inst_ack;
        end
        inst_req = 1'b0;
        check("t6_inst_ack", {63'd0, got}, 64'd1);
        busy_len = 3;

        repeat (4) @(negedge clock);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
